block_check_arbiter: RTL and testbench



---
 rtl/block_check_arbiter_if.sv | 32 +++
 rtl/block_check_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_block_check_arbiter.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/block_check_arbiter_if.sv
// Bus bundle between block_check_arbiter and its environment:
// the two byte-stream requesters, the BlockChecker connection and
// the per-requester verdict outputs.
interface block_check_arbiter_if;
   logic       req0_valid;
   logic [7:0] req0_data;
   logic       req0_ready;
   logic       req1_valid;
   logic [7:0] req1_data;
   logic       req1_ready;
   logic [7:0] chk_in;
   logic       chk_reset;
   logic       chk_result;
   logic       done0;
   logic       done1;
   logic       verdict0;
   logic       verdict1;

   // Environment side: requesters plus the checker result.
   modport master (
      output req0_valid, req0_data, req1_valid, req1_data, chk_result,
      input  req0_ready, req1_ready, chk_in, chk_reset,
             done0, done1, verdict0, verdict1
   );

   // Arbiter side.
   modport slave (
      input  req0_valid, req0_data, req1_valid, req1_data, chk_result,
      output req0_ready, req1_ready, chk_in, chk_reset,
             done0, done1, verdict0, verdict1
   );
endinterface

// File: rtl/block_check_arbiter.sv
// block_check_arbiter: grants the shared BlockChecker to one of two
// requesters for a whole newline-terminated message, clears the checker
// first, buffers each word and replays it without gaps (the checker
// cannot be stalled), then returns the checker verdict to the owner.
// Optional build macro BCA_FIXED_PRIO_EN: requester 0 always wins
// simultaneous requests; otherwise arbitration is round-robin.
module block_check_arbiter #(
   parameter int         MAX_WORD = 8,
   parameter logic [7:0] TERM     = 8'h0A
) (
   input  logic                 clk,
   input  logic                 reset,
   block_check_arbiter_if.slave bus
);
   localparam int              CW          = $clog2(MAX_WORD + 1);
   localparam int              AW          = (MAX_WORD > 1) ? $clog2(MAX_WORD) : 1;
   localparam logic [7:0]      SPACE       = 8'h20;
   localparam logic [7:0]      LONG_SUBST  = 8'h78;
   localparam logic [CW-1:0]   CNT_MAX     = CW'(MAX_WORD);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLR,
      S_COLLECT,
      S_REPLAY,
      S_SEP,
      S_SAMPLE,
      S_REPORT
   } state_t;

   state_t        state_q, state_d;
   logic          owner_q, owner_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] idx_q, idx_d;
   logic          long_q, long_d;
   logic          is_term_q, is_term_d;
   logic          verdict0_q, verdict0_d;
   logic          verdict1_q, verdict1_d;
`ifndef BCA_FIXED_PRIO_EN
   logic          last_q, last_d;
`endif

   // Word buffer holds data only; it is never reset.
   logic [7:0]    wbuf_q [MAX_WORD];
   logic          wbuf_we;
   logic [AW-1:0] wbuf_waddr;

   logic          own_valid;
   logic [7:0]    own_data;
   logic          grant1;

   assign own_valid = owner_q ? bus.req1_valid : bus.req0_valid;
   assign own_data  = owner_q ? bus.req1_data  : bus.req0_data;

   // grant1 is only consulted when at least one requester is valid.
`ifdef BCA_FIXED_PRIO_EN
   assign grant1 = !bus.req0_valid;
`else
   assign grant1 = (bus.req0_valid && bus.req1_valid) ? ~last_q : bus.req1_valid;
`endif

   // Next-state logic for the message sequencer.
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      long_d     = long_q;
      is_term_d  = is_term_q;
      verdict0_d = verdict0_q;
      verdict1_d = verdict1_q;
      wbuf_we    = 1'b0;
      wbuf_waddr = cnt_q[AW-1:0];
`ifndef BCA_FIXED_PRIO_EN
      last_d     = last_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (bus.req0_valid || bus.req1_valid) begin
               owner_d = grant1;
               state_d = S_CLR;
            end
         end
         S_CLR: begin
            state_d = S_COLLECT;
         end
         S_COLLECT: begin
            if (own_valid) begin
               if (own_data == SPACE || own_data == TERM) begin
                  is_term_d = (own_data == TERM);
                  idx_d     = '0;
                  // An empty word has nothing to replay.
                  state_d   = (cnt_q == '0 && !long_q) ? S_SEP : S_REPLAY;
               end else if (cnt_q == CNT_MAX) begin
                  long_d = 1'b1;
               end else begin
                  wbuf_we = 1'b1;
                  cnt_d   = cnt_q + CW'(1);
               end
            end
         end
         S_REPLAY: begin
            // An over-long word is replayed as a single substitute byte.
            if (long_q || idx_q == cnt_q - CW'(1)) begin
               state_d = S_SEP;
            end else begin
               idx_d = idx_q + CW'(1);
            end
         end
         S_SEP: begin
            cnt_d   = '0;
            idx_d   = '0;
            long_d  = 1'b0;
            state_d = is_term_q ? S_SAMPLE : S_COLLECT;
         end
         S_SAMPLE: begin
            if (owner_q) verdict1_d = bus.chk_result;
            else         verdict0_d = bus.chk_result;
            state_d = S_REPORT;
         end
         S_REPORT: begin
`ifndef BCA_FIXED_PRIO_EN
            last_d  = owner_q;
`endif
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Control and verdict registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         owner_q    <= 1'b0;
         cnt_q      <= '0;
         idx_q      <= '0;
         long_q     <= 1'b0;
         is_term_q  <= 1'b0;
         verdict0_q <= 1'b0;
         verdict1_q <= 1'b0;
`ifndef BCA_FIXED_PRIO_EN
         last_q     <= 1'b1;
`endif
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         long_q     <= long_d;
         is_term_q  <= is_term_d;
         verdict0_q <= verdict0_d;
         verdict1_q <= verdict1_d;
`ifndef BCA_FIXED_PRIO_EN
         last_q     <= last_d;
`endif
      end
   end

   // Word buffer write port.
   always_ff @(posedge clk) begin
      if (wbuf_we) begin
         wbuf_q[wbuf_waddr] <= own_data;
      end
   end

   // Checker input: spaces everywhere except while replaying a word.
   always_comb begin
      bus.chk_in = SPACE;
      if (!reset && state_q == S_REPLAY) begin
         bus.chk_in = long_q ? LONG_SUBST : wbuf_q[idx_q[AW-1:0]];
      end
   end

   assign bus.chk_reset  = reset | (state_q == S_CLR);
   assign bus.req0_ready = !reset && (state_q == S_COLLECT) && !owner_q;
   assign bus.req1_ready = !reset && (state_q == S_COLLECT) &&  owner_q;
   assign bus.done0      = !reset && (state_q == S_REPORT)  && !owner_q;
   assign bus.done1      = !reset && (state_q == S_REPORT)  &&  owner_q;
   assign bus.verdict0   = verdict0_q;
   assign bus.verdict1   = verdict1_q;

endmodule

// File: tb/tb_block_check_arbiter.sv
// Testbench for block_check_arbiter: models the BlockChecker, drives both
// requesters, and compares verdicts, done pulses, grant order and the
// byte stream seen by the checker against expectations.
`timescale 1ns/1ps
module tb_block_check_arbiter;
   localparam int MAX_WORD = 8;
   localparam int TMO      = 2000;

   logic clk = 1'b0;
   logic reset;

   // Free-running clock.
   always #5 clk = ~clk;

   block_check_arbiter_if bus();

   block_check_arbiter #(.MAX_WORD(MAX_WORD), .TERM(8'h0A)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   function automatic void check(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endfunction

   function automatic void check_str(string name, string act, string exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got \"%s\", required \"%s\"", name, act, exp);
      end
   endfunction

   // ---------------- BlockChecker model ----------------
   logic [7:0] mw [16];
   int         ml = 0;
   int         md = 0;
   bit         mneg = 1'b0;

   function automatic logic [7:0] lc(logic [7:0] b);
      return (b >= 8'h41 && b <= 8'h5A) ? b + 8'd32 : b;
   endfunction

   // Checker: case-insensitive begin/end nesting over space-separated words.
   always @(posedge clk) begin
      if (bus.chk_reset) begin
         ml   <= 0;
         md   <= 0;
         mneg <= 1'b0;
      end else if (bus.chk_in == 8'h20) begin
         if (ml == 5 && {mw[0], mw[1], mw[2], mw[3], mw[4]} == "begin") begin
            md <= md + 1;
         end else if (ml == 3 && {mw[0], mw[1], mw[2]} == "end") begin
            if (md == 0) mneg <= 1'b1;
            else         md <= md - 1;
         end
         ml <= 0;
      end else begin
         if (ml < 16)  mw[ml] <= lc(bus.chk_in);
         if (ml < 100) ml <= ml + 1;
      end
   end

   assign bus.chk_result = (md == 0) && !mneg;

   // ---------------- reference model ----------------
   function automatic bit ref_verdict(string msg);
      int    depth = 0;
      bit    ok = 1'b1;
      string w = "";
      byte   c;
      for (int i = 0; i < msg.len(); i++) begin
         c = msg[i];
         if (c == 8'h20 || c == 8'h0A) begin
            if (w.len() <= MAX_WORD) begin
               if (w.tolower() == "begin") depth++;
               else if (w.tolower() == "end") begin
                  if (depth == 0) ok = 1'b0;
                  else depth--;
               end
            end
            w = "";
            if (c == 8'h0A) break;
         end else begin
            w = {w, $sformatf("%c", c)};
         end
      end
      return ok && (depth == 0);
   endfunction

   function automatic string pick_word(int k);
      case (k)
         0: return "begin";
         1: return "end";
         2: return "BEGIN";
         3: return "End";
         4: return "foo";
         5: return "x";
         6: return "beginning";
         7: return "abcdefgh";
         8: return "abcdefghi";
         default: return "";
      endcase
   endfunction

   function automatic string rand_msg();
      string m = "";
      int    n = int'($urandom_range(0, 5));
      for (int i = 0; i < n; i++) begin
         m = {m, pick_word(int'($urandom_range(0, 9)))};
         if (i != n - 1) m = {m, " "};
      end
      return {m, "\n"};
   endfunction

   // ---------------- monitors ----------------
   bit    exp_q0[$];
   bit    exp_q1[$];
   int    order_q[$];
   int    done_cnt0 = 0;
   int    done_cnt1 = 0;
   bit    pd0 = 1'b0;
   bit    pd1 = 1'b0;
   string stream = "";
   int    active = -1;
   int    stray = 0;
   int    both = 0;
   bit    abort = 1'b0;

   // Done pulses, verdict scoreboard, checker stream capture, ready exclusivity.
   always @(negedge clk) begin
      if (!reset) begin
         if (bus.done0) begin
            check("done0 single-cycle", pd0, 0);
            check("done0/done1 exclusive", bus.done1, 0);
            check("done0 has pending message", int'(exp_q0.size() > 0), 1);
            if (exp_q0.size() > 0) check("verdict0 scoreboard", bus.verdict0, exp_q0.pop_front());
            done_cnt0++;
            order_q.push_back(0);
         end
         if (bus.done1) begin
            check("done1 single-cycle", pd1, 0);
            check("done1 has pending message", int'(exp_q1.size() > 0), 1);
            if (exp_q1.size() > 0) check("verdict1 scoreboard", bus.verdict1, exp_q1.pop_front());
            done_cnt1++;
            order_q.push_back(1);
         end
      end
      if (bus.chk_in != 8'h20) stream = {stream, $sformatf("%c", bus.chk_in)};
      else if (stream.len() > 0 && stream[stream.len()-1] != 8'h20) stream = {stream, " "};
      if (active == 0 && bus.req1_ready) stray++;
      if (active == 1 && bus.req0_ready) stray++;
      if (bus.req0_ready && bus.req1_ready) both++;
      pd0 = bus.done0;
      pd1 = bus.done1;
   end

   function automatic string trim(string s);
      if (s.len() > 0 && s[s.len()-1] == 8'h20) return s.substr(0, s.len() - 2);
      return s;
   endfunction

   // ---------------- drivers ----------------
   task automatic set_req(input int r, input logic v, input logic [7:0] d);
      if (r == 0) begin bus.req0_valid = v; bus.req0_data = d; end
      else        begin bus.req1_valid = v; bus.req1_data = d; end
   endtask

   function automatic logic rdy(int r);
      return (r == 0) ? bus.req0_ready : bus.req1_ready;
   endfunction

   task automatic send(input int r, input string msg, input int maxgap);
      int gap;
      int t;
      for (int i = 0; i < msg.len(); i++) begin
         gap = (maxgap > 0) ? int'($urandom_range(0, unsigned'(maxgap))) : 0;
         for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            set_req(r, 1'b0, 8'h00);
         end
         @(negedge clk);
         if (abort) break;
         set_req(r, 1'b1, msg[i]);
         t = 0;
         while (!rdy(r) && !abort && t < TMO) begin
            @(negedge clk);
            t++;
         end
         check("handshake within bound", int'(t < TMO), 1);
         if (abort || t >= TMO) break;
         @(posedge clk);
      end
      @(negedge clk);
      set_req(r, 1'b0, 8'h00);
   endtask

   task automatic wait_dones(input int target);
      int t = 0;
      while (done_cnt0 + done_cnt1 < target && t < TMO) begin
         @(negedge clk);
         t++;
      end
      check("done count", done_cnt0 + done_cnt1, target);
   endtask

   typedef struct {
      int    req;
      string msg;
      bit    exp_v;
      string exp_s;
   } vec_t;

   vec_t vq[$];

   task automatic add_vec(input int r, input string m, input bit v, input string s);
      vec_t x;
      x.req = r; x.msg = m; x.exp_v = v; x.exp_s = s;
      vq.push_back(x);
   endtask

   // ---------------- main sequence ----------------
   int  base;
   bit  other_before;
   int  exp_order[3];
   int  t0;
   string m0;
   string m1;

   initial begin
      reset = 1'b1;
      set_req(0, 1'b0, 8'h00);
      set_req(1, 1'b0, 8'h00);

      add_vec(0, "begin end\n",            1'b1, "begin end");
      add_vec(1, "BeGin\n",                1'b0, "BeGin");
      add_vec(0, "beginning end\n",        1'b0, "x end");
      add_vec(0, "begin xyzzyxyzzy end\n", 1'b1, "begin x end");
      add_vec(0, "\n",                     1'b1, "");
      add_vec(1, "end begin\n",            1'b0, "end begin");
      add_vec(0, "abcdefgh end\n",         1'b0, "abcdefgh end");
      add_vec(1, "begin  BEGIN end END\n", 1'b1, "begin BEGIN end END");
      add_vec(0, " begin end \n",          1'b1, "begin end");

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      check("reset chk_in",     bus.chk_in, 8'h20);
      check("reset chk_reset",  bus.chk_reset, 1);
      check("reset req0_ready", bus.req0_ready, 0);
      check("reset req1_ready", bus.req1_ready, 0);
      check("reset done0",      bus.done0, 0);
      check("reset verdict0",   bus.verdict0, 0);
      check("reset verdict1",   bus.verdict1, 0);

      // Grant latency and message latency for an empty message.
      @(negedge clk);
      reset = 1'b0;
      exp_q0.push_back(1'b1);
      set_req(0, 1'b1, 8'h0A);
      @(negedge clk);
      check("CLR chk_reset",      bus.chk_reset, 1);
      check("CLR req0_ready",     bus.req0_ready, 0);
      @(negedge clk);
      check("COLLECT req0_ready", bus.req0_ready, 1);
      check("COLLECT chk_reset",  bus.chk_reset, 0);
      @(negedge clk);
      set_req(0, 1'b0, 8'h00);
      check("SEP done0",  bus.done0, 0);
      check("SEP chk_in", bus.chk_in, 8'h20);
      @(negedge clk);
      check("SAMPLE done0", bus.done0, 0);
      @(negedge clk);
      check("REPORT done0",    bus.done0, 1);
      check("REPORT verdict0", bus.verdict0, 1);
      @(negedge clk);

      // Table-driven single-requester messages.
      for (int i = 0; i < vq.size(); i++) begin
         base = done_cnt0 + done_cnt1;
         other_before = (vq[i].req == 0) ? bus.verdict1 : bus.verdict0;
         if (vq[i].req == 0) exp_q0.push_back(vq[i].exp_v);
         else                exp_q1.push_back(vq[i].exp_v);
         order_q.delete();
         stray  = 0;
         stream = "";
         active = vq[i].req;
         send(vq[i].req, vq[i].msg, 1);
         wait_dones(base + 1);
         active = -1;
         check($sformatf("vec%0d owner done", i), (order_q.size() > 0) ? order_q[0] : -1, vq[i].req);
         check($sformatf("vec%0d verdict", i),
               (vq[i].req == 0) ? bus.verdict0 : bus.verdict1, vq[i].exp_v);
         check($sformatf("vec%0d other verdict held", i),
               (vq[i].req == 0) ? bus.verdict1 : bus.verdict0, other_before);
         check($sformatf("vec%0d non-owner ready", i), stray, 0);
         check_str($sformatf("vec%0d checker stream", i), trim(stream), vq[i].exp_s);
      end

      // Arbitration with both requesters continuously valid.
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      order_q.delete();
      base = done_cnt0 + done_cnt1;
      exp_q0.push_back(1'b0);
      exp_q0.push_back(1'b0);
      exp_q1.push_back(1'b1);
`ifdef BCA_FIXED_PRIO_EN
      exp_order = '{0, 0, 1};
`else
      exp_order = '{0, 1, 0};
`endif
      fork
         begin
            send(0, "end\n", 0);
            send(0, "end\n", 0);
         end
         begin
            send(1, "begin end\n", 0);
         end
      join
      wait_dones(base + 3);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("grant order %0d", k), (order_q.size() > k) ? order_q[k] : -1, exp_order[k]);
      end

      // Reset while replaying "begin".
      @(negedge clk);
      set_req(0, 1'b0, 8'h00);
      exp_q0.push_back(1'b1);
      active = 0;
      stray  = 0;
      send(0, "begin end\n", 0);
      wait_dones(done_cnt0 + done_cnt1 + 1);
      active = -1;
      check("pre-reset verdict0", bus.verdict0, 1);
      base = done_cnt0 + done_cnt1;
      fork
         begin
            send(0, "begin end\n", 0);
         end
         begin
            t0 = 0;
            while (bus.chk_in != 8'h62 && t0 < TMO) begin
               @(negedge clk);
               t0++;
            end
            check("replay of 'b' reached", int'(bus.chk_in), 8'h62);
            reset = 1'b1;
            abort = 1'b1;
            @(posedge clk);
            #1;
            check("mid reset chk_reset",  bus.chk_reset, 1);
            check("mid reset chk_in",     bus.chk_in, 8'h20);
            check("mid reset req0_ready", bus.req0_ready, 0);
            check("mid reset done0",      bus.done0, 0);
            check("mid reset verdict0",   bus.verdict0, 0);
            check("mid reset verdict1",   bus.verdict1, 0);
         end
      join
      exp_q0.delete();
      @(negedge clk);
      reset = 1'b0;
      abort = 1'b0;
      @(negedge clk);
      check("after reset idle chk_in",     bus.chk_in, 8'h20);
      check("after reset idle chk_reset",  bus.chk_reset, 0);
      check("after reset idle req0_ready", bus.req0_ready, 0);
      repeat (5) @(negedge clk);
      check("no done after reset", done_cnt0 + done_cnt1, base);
      exp_q0.push_back(1'b1);
      send(0, "begin end\n", 0);
      wait_dones(base + 1);
      check("post-reset verdict0", bus.verdict0, 1);

      // Randomized concurrent traffic against the reference model.
      base = done_cnt0 + done_cnt1;
      fork
         begin
            for (int k = 0; k < 15; k++) begin
               m0 = rand_msg();
               exp_q0.push_back(ref_verdict(m0));
               send(0, m0, 2);
            end
         end
         begin
            for (int k = 0; k < 15; k++) begin
               m1 = rand_msg();
               exp_q1.push_back(ref_verdict(m1));
               send(1, m1, 2);
            end
         end
      join
      wait_dones(base + 30);
      check("random queue0 drained", exp_q0.size(), 0);
      check("random queue1 drained", exp_q1.size(), 0);
      check("readies never both high", both, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
